// File: rtl/binary_counter_pkg.sv
// Shared types and defaults for the prescaled LED down-counter.
package binary_counter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam int unsigned DEF_LED_WIDTH = 8;
  localparam logic [7:0]  DEF_RELOAD    = 8'hFF;

endpackage

// File: rtl/binary_downcounter_tick_prescaler.sv
// Free-running clock prescaler: strobe is high for one enabled cycle every COUNT+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned COUNT       = 12_000_000 - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam logic [COUNT_WIDTH-1:0] TERM = COUNT_WIDTH'(COUNT);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   at_term;

  assign at_term = (cnt_q == TERM);
  assign strobe  = en && at_term;

  // clr wins over en so a load or a finished one-shot always restarts a full period
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (at_term) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/binary_downcounter.sv
// Prescaled LED down-counter with preload and terminal-count pulse.
// Define BINARY_DOWNCOUNTER_ONESHOT_EN to stop at zero instead of wrapping to RELOAD.
module binary_downcounter
  import binary_counter_pkg::*;
#(
  parameter int unsigned            COUNT_WIDTH = 24,
  parameter int unsigned            COUNT       = 12_000_000 - 1,
  parameter int unsigned            LED_WIDTH   = DEF_LED_WIDTH,
  parameter logic [LED_WIDTH-1:0]   RELOAD      = LED_WIDTH'(DEF_RELOAD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [LED_WIDTH-1:0] load_val,
  output logic [LED_WIDTH-1:0] led,
  output logic                 tick,
  output logic                 tc
);

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 tick_q, tick_d;
  logic                 tc_q, tc_d;
  logic                 strobe;
  logic                 pre_clr;

  tick_prescaler #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .COUNT       (COUNT)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (pre_clr),
    .strobe (strobe)
  );

`ifdef BINARY_DOWNCOUNTER_ONESHOT_EN
  state_e state_q, state_d;

  // Prescaler is parked at zero while finished or while sitting at zero after a load of 0
  assign pre_clr = load || (state_q == ST_DONE) || (led_q == '0);

  always_comb begin
    led_d   = led_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    state_d = state_q;
    if (load) begin
      led_d   = load_val;
      state_d = ST_RUN;
    end else if (state_q == ST_DONE) begin
      led_d = '0;
    end else if (led_q == '0) begin
      state_d = ST_DONE;
    end else if (strobe) begin
      tick_d = 1'b1;
      if (led_q == LED_WIDTH'(1)) begin
        led_d   = '0;
        tc_d    = 1'b1;
        state_d = ST_DONE;
      end else begin
        led_d = led_q - LED_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign pre_clr = load;

  // Zero wraps to RELOAD rather than to all-ones
  always_comb begin
    led_d  = led_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      led_d = load_val;
    end else if (strobe) begin
      tick_d = 1'b1;
      if (led_q == '0) begin
        led_d = RELOAD;
        tc_d  = 1'b1;
      end else begin
        led_d = led_q - LED_WIDTH'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= RELOAD;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      led_q  <= led_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_binary_downcounter.sv
// Directed bench for binary_downcounter with a tick scoreboard (COUNT=999, 80 ns clock).
module tb_binary_downcounter;

  localparam int CW  = 12;
  localparam int CNT = 999;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] led;
  logic       tick;
  logic       tc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] led;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  logic tick_prev = 1'b0;

  always #40 clk = ~clk;

  binary_downcounter #(
    .COUNT_WIDTH (CW),
    .COUNT       (CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .tick     (tick),
    .tc       (tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tick(input logic [7:0] l, input logic t);
    exp_t e;
    e.led = l;
    e.tc  = t;
    sb.push_back(e);
  endtask

  task automatic wait_tick(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick && cycles < limit);
  endtask

  // Scoreboard side: every tick must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (tc && !tick) chk("tc_without_tick", 32'(tc), 32'(tick));
      if (tick && tick_prev) chk("tick_width", 32'(tick_prev), 0);
      if (tick) begin
        if (sb.size() == 0) begin
          chk("unexpected_tick", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("sb_led", 32'(led), 32'(e.led));
          chk("sb_tc", 32'(tc), 32'(e.tc));
        end
      end
      tick_prev = tick;
    end else begin
      tick_prev = 1'b0;
    end
  end

  initial begin
    int c;
    int n;
    rst      = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;

    #100;
    chk("rst_led", 32'(led), 32'hFF);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_tc", 32'(tc), 0);
    #100;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    expect_tick(8'hFE, 1'b0);
    wait_tick(1100, c);
    chk("first_tick_cycles", 32'(c), 1000);
    expect_tick(8'hFD, 1'b0);
    expect_tick(8'hFC, 1'b0);
    for (int i = 0; i < 2; i++) begin
      wait_tick(1100, c);
      chk("period", 32'(c), 1000);
    end
    chk("after3_led", 32'(led), 32'hFC);

    load     = 1'b1;
    load_val = 8'h02;
    @(negedge clk);
    load = 1'b0;
    chk("load_led", 32'(led), 32'h02);
    chk("load_tick", 32'(tick), 0);
`ifndef BINARY_DOWNCOUNTER_ONESHOT_EN
    expect_tick(8'h01, 1'b0);
    expect_tick(8'h00, 1'b0);
    expect_tick(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(1100, c);
      chk("load_period", 32'(c), 1000);
    end
    chk("wrap_tc", 32'(tc), 1);
    @(negedge clk);
    chk("tc_pulse_end", 32'(tc), 0);
    chk("tick_pulse_end", 32'(tick), 0);
    expect_tick(8'hFE, 1'b0);
    wait_tick(1100, c);
    chk("period_after_pulse", 32'(c), 999);
`else
    expect_tick(8'h01, 1'b0);
    expect_tick(8'h00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_tick(1100, c);
      chk("load_period", 32'(c), 1000);
    end
    chk("oneshot_tc", 32'(tc), 1);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tick || tc) n++;
    end
    chk("done_quiet", 32'(n), 0);
    chk("done_led", 32'(led), 0);
    load     = 1'b1;
    load_val = 8'h05;
    @(negedge clk);
    load = 1'b0;
    chk("resume_led", 32'(led), 32'h05);
    expect_tick(8'h04, 1'b0);
    wait_tick(1100, c);
    chk("resume_period", 32'(c), 1000);
`endif

    // Load lands on the terminal-count edge and must swallow that tick
    repeat (999) @(negedge clk);
    load     = 1'b1;
    load_val = 8'h40;
    @(negedge clk);
    load = 1'b0;
    chk("term_load_led", 32'(led), 32'h40);
    chk("term_load_tick", 32'(tick), 0);
    expect_tick(8'h3F, 1'b0);
    wait_tick(1100, c);
    chk("term_load_period", 32'(c), 1000);

    repeat (300) @(negedge clk);
    en = 1'b0;
    repeat (500) @(negedge clk);
    chk("frozen_led", 32'(led), 32'h3F);
    en = 1'b1;
    expect_tick(8'h3E, 1'b0);
    wait_tick(1100, c);
    chk("en_gap_cycles", 32'(c), 700);

    for (int k = 0; k < 20; k++) expect_tick(8'h3D - 8'(k), 1'b0);
    n = 0;
    for (int i = 0; i < 25000; i++) begin
      if (i == 10000) en = 1'b0;
      if (i == 15000) en = 1'b1;
      @(negedge clk);
      if (tick) n++;
    end
    chk("window_ticks", 32'(n), 20);
    chk("window_led", 32'(led), 32'h2A);

`ifndef BINARY_DOWNCOUNTER_ONESHOT_EN
    load     = 1'b1;
    load_val = 8'h00;
    @(negedge clk);
    load = 1'b0;
    chk("load0_led", 32'(led), 0);
    expect_tick(8'hFF, 1'b1);
    wait_tick(1100, c);
    chk("load0_period", 32'(c), 1000);
    chk("load0_tc", 32'(tc), 1);
`else
    load     = 1'b1;
    load_val = 8'h00;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tick || tc) n++;
    end
    chk("load0_quiet", 32'(n), 0);
    chk("load0_led", 32'(led), 0);
`endif

    load     = 1'b1;
    load_val = 8'hA0;
    @(negedge clk);
    load = 1'b0;
    repeat (400) @(negedge clk);
    chk("mid_led", 32'(led), 32'hA0);
    #20;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'hFF);
    chk("async_rst_tick", 32'(tick), 0);
    #200;
    @(negedge clk);
    rst = 1'b0;
    expect_tick(8'hFE, 1'b0);
    wait_tick(1100, c);
    chk("post_rst_period", 32'(c), 1000);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
